// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the pipelined barrel shifter.
// Contents:
//   shift_mode_t      - encodings of the five real shift modes
//   MODE_PASS         - canonical encoding used for every pass-through mode
//   level_stage       - which register stage a given shift level lives in
//   stage_first_level - first shift level handled by a given stage
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROR = 3'b011,
    ROL = 3'b100
  } shift_mode_t;

  localparam logic [2:0] MODE_PASS = 3'b101;

  // Level i goes to stage floor(i*stages/levels).
  function automatic int level_stage(input int level, input int stages, input int levels);
    return (level * stages) / levels;
  endfunction

  // Inverse of level_stage: smallest level whose stage index is >= stage.
  // Because stages <= levels, every stage owns at least one level, so the
  // levels of stage s are stage_first_level(s) .. stage_first_level(s+1)-1.
  function automatic int stage_first_level(input int stage, input int stages, input int levels);
    return (stage * levels + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one register stage of the pipelined barrel shifter.
// Applies shift levels LO_LEVEL..HI_LEVEL combinationally, then registers
// the partial result together with everything later stages still need.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   en                  common load enable (low while the pipe is stalled)
//   in_valid/out_valid  beat-present flag
//   in_data/out_data    partial shift result
//   in_amt/out_amt      full shift amount (later stages read their own bits)
//   in_mode/out_mode    shift mode
//   in_fill/out_fill    original operand MSB, used as SRA fill at every level
//   in_carry/out_carry  carry computed at pipe entry
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LO_LEVEL = 0,
  parameter int HI_LEVEL = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_mode,
  input  logic                     in_fill,
  input  logic                     in_carry,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_amt,
  output logic [2:0]               out_mode,
  output logic                     out_fill,
  output logic                     out_carry
);

  logic [WIDTH-1:0] shifted;

  // One level of the barrel: shift by k in the selected mode. SRA takes its
  // fill from the carried original MSB, never from the partial result.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int k,
                                                   input logic [2:0] mode,
                                                   input logic fill);
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] res;
    fill_mask = ~({WIDTH{1'b1}} >> k);
    case (shift_mode_t'(mode))
      SLL:     res = d << k;
      SRL:     res = d >> k;
      SRA:     res = (d >> k) | (fill ? fill_mask : '0);
      ROR:     res = (d >> k) | (d << (WIDTH - k));
      ROL:     res = (d << k) | (d >> (WIDTH - k));
      default: res = d;
    endcase
    return res;
  endfunction

  always_comb begin
    shifted = in_data;
    for (int lvl = LO_LEVEL; lvl <= HI_LEVEL; lvl++) begin
      if (in_amt[lvl]) shifted = shift_level(shifted, 1 << lvl, in_mode, in_fill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= '0;
      out_fill  <= 1'b0;
      out_carry <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
      out_fill  <= in_fill;
      out_carry <= in_carry;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: parametrised barrel shifter (SLL/SRL/SRA/ROR/ROL plus
// pass-through) split across STAGES register stages with valid/ready flow
// control and a global stall.
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   in_valid, in_ready       input handshake
//   in_data, in_amt, in_mode operand, unsigned shift amount, mode
//   out_valid, out_ready     output handshake
//   out_data                 shifted result
//   out_zero                 out_data == 0
//   out_carry                last bit shifted/rotated out (0 when amt == 0)
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_carry
);

  localparam int AW = $clog2(WIDTH);

  // Index s is the input of stage s; index STAGES is the output register.
  logic             valid_c [0:STAGES];
  logic [WIDTH-1:0] data_c  [0:STAGES];
  logic [AW-1:0]    amt_c   [0:STAGES];
  logic [2:0]       mode_c  [0:STAGES];
  logic             fill_c  [0:STAGES];
  logic             carry_c [0:STAGES];

  logic             advance;
  logic             carry_in;
  logic [AW-1:0]    neg_amt;
  logic [AW-1:0]    amt_m1;
  logic             unused_tail;

  // A stalled output freezes the whole pipe, bubbles included, so in_ready
  // depends only on out_valid and out_ready.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Carry is taken from the original operand: SLL and ROL lose bit
  // WIDTH-amt, SRL/SRA/ROR lose bit amt-1. Modulo-WIDTH arithmetic on the
  // amount gives those indices directly once amt == 0 is excluded.
  assign neg_amt = AW'(0) - in_amt;
  assign amt_m1  = in_amt - AW'(1);

  always_comb begin
    carry_in = 1'b0;
    if (in_amt != '0) begin
      case (in_mode)
        SLL, ROL:      carry_in = in_data[neg_amt];
        SRL, SRA, ROR: carry_in = in_data[amt_m1];
        default:       carry_in = 1'b0;
      endcase
    end
  end

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign amt_c[0]   = in_amt;
  assign mode_c[0]  = (in_mode > 3'(ROL)) ? MODE_PASS : in_mode;
  assign fill_c[0]  = in_data[WIDTH-1];
  assign carry_c[0] = carry_in;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    shifter_stage #(
      .WIDTH    (WIDTH),
      .LO_LEVEL (stage_first_level(s, STAGES, AW)),
      .HI_LEVEL (stage_first_level(s + 1, STAGES, AW) - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (valid_c[s]),
      .in_data   (data_c[s]),
      .in_amt    (amt_c[s]),
      .in_mode   (mode_c[s]),
      .in_fill   (fill_c[s]),
      .in_carry  (carry_c[s]),
      .out_valid (valid_c[s+1]),
      .out_data  (data_c[s+1]),
      .out_amt   (amt_c[s+1]),
      .out_mode  (mode_c[s+1]),
      .out_fill  (fill_c[s+1]),
      .out_carry (carry_c[s+1])
    );
  end

  assign out_valid = valid_c[STAGES];
  assign out_data  = data_c[STAGES];
  assign out_carry = carry_c[STAGES];
  assign out_zero  = (data_c[STAGES] == '0);

  // Side-band fields are spent by the time they reach the output register.
  assign unused_tail = ^{amt_c[STAGES], mode_c[STAGES], fill_c[STAGES]};

endmodule
